// File: rtl/adsr_env.sv
// adsr_env: ADSR envelope generator. The envelope is Q2.14 (0x4000 = 1.0) and
// is taken from the top 16 bits of an ACC_WIDTH-bit accumulator.
// State, accumulator and gate history only move on clk edges where en is high.
// Optional build macro ADSR_HOLD_EN adds a HOLD stage at the peak, plus the
// hold_ticks port and its tick counter.
module adsr_env #(
  parameter int ACC_WIDTH = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        gate,
  input  logic [15:0] attack_step,
  input  logic [15:0] decay_step,
  input  logic [15:0] sustain_lvl,
  input  logic [15:0] release_step,
`ifdef ADSR_HOLD_EN
  input  logic [15:0] hold_ticks,
`endif
  output logic [15:0] env,
  output logic        env_valid,
  output logic        active
);

  localparam int SH = ACC_WIDTH - 16;
  // 1.0 in accumulator units: bit ACC_WIDTH-2 set.
  localparam logic [ACC_WIDTH-1:0] PEAK = {2'b01, {(ACC_WIDTH-2){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTACK,
`ifdef ADSR_HOLD_EN
    S_HOLD,
`endif
    S_DECAY,
    S_SUSTAIN,
    S_RELEASE
  } state_e;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 gate_q;
  logic                 env_valid_q;
`ifdef ADSR_HOLD_EN
  logic [15:0]          hold_cnt_q, hold_cnt_d;
`endif

  // Steps and sustain scaled into accumulator units.
  logic [15:0]          sus_clamp;
  logic [ACC_WIDTH-1:0] astep, dstep, rstep, sus_acc;
  logic [ACC_WIDTH:0]   att_sum, dec_lim;
  logic                 rise, dec_floor;

  assign sus_clamp = (sustain_lvl > 16'h4000) ? 16'h4000 : sustain_lvl;
  assign astep     = {attack_step,  {SH{1'b0}}};
  assign dstep     = {decay_step,   {SH{1'b0}}};
  assign rstep     = {release_step, {SH{1'b0}}};
  assign sus_acc   = {sus_clamp,    {SH{1'b0}}};
  // One extra bit so neither the attack sum nor the decay floor can wrap.
  assign att_sum   = {1'b0, acc_q} + {1'b0, astep};
  assign dec_lim   = {1'b0, dstep} + {1'b0, sus_acc};
  // acc - step <= sustain, rearranged to avoid a negative intermediate.
  assign dec_floor = ({1'b0, acc_q} <= dec_lim);
  assign rise      = gate & ~gate_q;

  // Next-state and accumulator update; gate-low outranks every other move,
  // and a state change consumes its tick without applying a step.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
`ifdef ADSR_HOLD_EN
    hold_cnt_d = hold_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        acc_d = '0;
        if (gate) state_d = S_ATTACK;
      end
      S_ATTACK: begin
        if (!gate) state_d = S_RELEASE;
        else if (astep != '0) begin
          if (att_sum >= {1'b0, PEAK}) begin
            acc_d = PEAK;
`ifdef ADSR_HOLD_EN
            state_d    = S_HOLD;
            hold_cnt_d = '0;
`else
            state_d = S_DECAY;
`endif
          end else begin
            acc_d = att_sum[ACC_WIDTH-1:0];
          end
        end
      end
`ifdef ADSR_HOLD_EN
      S_HOLD: begin
        if (!gate) state_d = S_RELEASE;
        else if (rise) state_d = S_ATTACK;
        else begin
          acc_d = PEAK;
          // Leave after the hold_ticks-th tick; 0 behaves like 1.
          if ({1'b0, hold_cnt_q} + 17'd1 >= {1'b0, hold_ticks}) begin
            state_d    = S_DECAY;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 16'd1;
          end
        end
      end
`endif
      S_DECAY: begin
        if (!gate) state_d = S_RELEASE;
        else if (rise) state_d = S_ATTACK;
        else if (dstep != '0) begin
          if (dec_floor) begin
            acc_d   = sus_acc;
            state_d = S_SUSTAIN;
          end else begin
            acc_d = acc_q - dstep;
          end
        end
      end
      S_SUSTAIN: begin
        if (!gate) state_d = S_RELEASE;
        else if (rise) state_d = S_ATTACK;
        else acc_d = sus_acc;
      end
      S_RELEASE: begin
        if (rise) state_d = S_ATTACK;
        else if (rstep != '0) begin
          if (acc_q <= rstep) begin
            acc_d   = '0;
            state_d = S_IDLE;
          end else begin
            acc_d = acc_q - rstep;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        acc_d   = '0;
      end
    endcase
  end

  // State, accumulator and gate history advance on en; env_valid trails en.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      gate_q      <= 1'b0;
      env_valid_q <= 1'b0;
`ifdef ADSR_HOLD_EN
      hold_cnt_q  <= '0;
`endif
    end else begin
      env_valid_q <= en;
      if (en) begin
        state_q <= state_d;
        acc_q   <= acc_d;
        gate_q  <= gate;
`ifdef ADSR_HOLD_EN
        hold_cnt_q <= hold_cnt_d;
`endif
      end
    end
  end

  assign env       = acc_q[ACC_WIDTH-1 -: 16];
  assign env_valid = env_valid_q;
  assign active    = (state_q != S_IDLE);

endmodule

// File: tb/tb_adsr_env.sv
// tb_adsr_env: directed bench for adsr_env. en is a one-clk pulse every four
// clocks; outputs are sampled on the falling edge right after the en edge.
// A gate change consumes its en tick without applying a step, so the first
// tick with gate high moves IDLE->ATTACK and env still reads 0.
module tb_adsr_env;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        gate = 1'b0;
  logic [15:0] attack_step = '0, decay_step = '0, sustain_lvl = '0, release_step = '0;
`ifdef ADSR_HOLD_EN
  logic [15:0] hold_ticks = '0;
`endif
  logic [15:0] env;
  logic        env_valid, active;

  int total = 0;
  int bad   = 0;

  adsr_env dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .gate         (gate),
    .attack_step  (attack_step),
    .decay_step   (decay_step),
    .sustain_lvl  (sustain_lvl),
    .release_step (release_step),
`ifdef ADSR_HOLD_EN
    .hold_ticks   (hold_ticks),
`endif
    .env          (env),
    .env_valid    (env_valid),
    .active       (active)
  );

  always #5 clk = ~clk;

  // One en pulse; returns on the falling edge after the en clock edge.
  task automatic tick();
    repeat (3) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++; if (env !== 16'h0000) begin bad++; $display("FAIL reset_env got=%h exp=0000", env); end
    total++; if (env_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", env_valid); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b exp=0", active); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // 0x100 per tick: 64 ticks after the entry tick land exactly on 0x4000.
  task automatic test_attack();
    logic [15:0] exp;
    attack_step = 16'h0100; decay_step = 16'h0080;
    sustain_lvl = 16'h2000; release_step = 16'h0100;
    gate = 1'b1;
    tick();
    total++; if (env !== 16'h0000 || active !== 1'b1) begin bad++; $display("FAIL attack_entry env=%h act=%b exp=0000/1", env, active); end
    for (int i = 1; i <= 64; i++) begin
      tick();
      exp = 16'(i * 256);
      total++; if (env !== exp) begin bad++; $display("FAIL attack_ramp[%0d] got=%h exp=%h", i, env, exp); end
    end
  endtask

  // Decay starts on the tick right after the peak and floors at sustain.
  task automatic test_decay_sustain();
    logic [15:0] exp;
    for (int i = 1; i <= 64; i++) begin
      tick();
      exp = 16'h4000 - 16'(i * 128);
      total++; if (env !== exp) begin bad++; $display("FAIL decay[%0d] got=%h exp=%h", i, env, exp); end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (env !== 16'h2000) begin bad++; $display("FAIL sustain_hold[%0d] got=%h exp=2000", i, env); end
    end
    sustain_lvl = 16'h1000;
    tick();
    total++; if (env !== 16'h1000) begin bad++; $display("FAIL sustain_track got=%h exp=1000", env); end
    sustain_lvl = 16'h5000;
    tick();
    total++; if (env !== 16'h4000) begin bad++; $display("FAIL sustain_clamp got=%h exp=4000", env); end
    sustain_lvl = 16'h2000;
    tick();
    total++; if (env !== 16'h2000) begin bad++; $display("FAIL sustain_back got=%h exp=2000", env); end
  endtask

  task automatic test_release();
    logic [15:0] exp;
    gate = 1'b0;
    tick();
    total++; if (env !== 16'h2000 || active !== 1'b1) begin bad++; $display("FAIL release_entry env=%h act=%b exp=2000/1", env, active); end
    for (int i = 1; i <= 32; i++) begin
      tick();
      exp = 16'h2000 - 16'(i * 256);
      total++; if (env !== exp) begin bad++; $display("FAIL release[%0d] got=%h exp=%h", i, env, exp); end
    end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL release_idle act=%b exp=0", active); end
    tick();
    total++; if (env !== 16'h0000 || active !== 1'b0) begin bad++; $display("FAIL idle_stay env=%h act=%b exp=0000/0", env, active); end
  endtask

  // Gate drops at 0x1800, four release steps to 0x1400, re-attack from there.
  task automatic test_retrigger();
    gate = 1'b1;
    tick();
    for (int i = 0; i < 24; i++) tick();
    total++; if (env !== 16'h1800) begin bad++; $display("FAIL retrig_pre got=%h exp=1800", env); end
    gate = 1'b0;
    tick();
    total++; if (env !== 16'h1800) begin bad++; $display("FAIL retrig_gateoff got=%h exp=1800", env); end
    for (int i = 0; i < 4; i++) tick();
    total++; if (env !== 16'h1400) begin bad++; $display("FAIL retrig_rel got=%h exp=1400", env); end
    gate = 1'b1;
    tick();
    total++; if (env !== 16'h1400) begin bad++; $display("FAIL retrig_edge got=%h exp=1400", env); end
    tick();
    total++; if (env !== 16'h1500) begin bad++; $display("FAIL retrig_up1 got=%h exp=1500", env); end
    tick();
    total++; if (env !== 16'h1600) begin bad++; $display("FAIL retrig_up2 got=%h exp=1600", env); end
  endtask

  task automatic test_zero_step();
    attack_step = 16'h0000;
    for (int i = 0; i < 3; i++) tick();
    total++; if (env !== 16'h1600 || active !== 1'b1) begin bad++; $display("FAIL zero_attack env=%h act=%b exp=1600/1", env, active); end
    attack_step = 16'h0100;
  endtask

  // Reach sustain quickly, then assert reset between clock edges.
  task automatic test_reset_mid();
    do_reset();
    gate = 1'b0;
    tick();
    attack_step = 16'h1000; decay_step = 16'h1000; sustain_lvl = 16'h2000;
    gate = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    total++; if (env !== 16'h2000) begin bad++; $display("FAIL mid_sustain got=%h exp=2000", env); end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++; if (env !== 16'h0000 || env_valid !== 1'b0 || active !== 1'b0) begin
      bad++; $display("FAIL mid_reset env=%h vld=%b act=%b exp=0000/0/0", env, env_valid, active);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    total++; if (env !== 16'h0000 || active !== 1'b1 || env_valid !== 1'b1) begin
      bad++; $display("FAIL post_reset env=%h act=%b vld=%b exp=0000/1/1", env, active, env_valid);
    end
    @(negedge clk);
    total++; if (env_valid !== 1'b0) begin bad++; $display("FAIL valid_pulse got=%b exp=0", env_valid); end
    tick();
    total++; if (env !== 16'h1000 || env_valid !== 1'b1) begin bad++; $display("FAIL post_reset_up env=%h vld=%b exp=1000/1", env, env_valid); end
    @(negedge clk);
    total++; if (env_valid !== 1'b0) begin bad++; $display("FAIL valid_pulse2 got=%b exp=0", env_valid); end
  endtask

`ifdef ADSR_HOLD_EN
  task automatic test_hold();
    do_reset();
    gate = 1'b0;
    tick();
    attack_step = 16'h2000; decay_step = 16'h0080;
    sustain_lvl = 16'h2000; hold_ticks = 16'd10;
    gate = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    total++; if (env !== 16'h4000) begin bad++; $display("FAIL hold_peak got=%h exp=4000", env); end
    for (int i = 1; i <= 10; i++) begin
      tick();
      total++; if (env !== 16'h4000) begin bad++; $display("FAIL hold[%0d] got=%h exp=4000", i, env); end
    end
    tick();
    total++; if (env !== 16'h3F80) begin bad++; $display("FAIL hold_decay got=%h exp=3f80", env); end
  endtask
`endif

  initial begin
    test_reset();
    test_attack();
    test_decay_sustain();
    test_release();
    test_retrigger();
    test_zero_step();
    test_reset_mid();
`ifdef ADSR_HOLD_EN
    test_hold();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adsr_env.md
ADSR_ENV -- requirements
Module: adsr_env

Interface
REQ-001 Parameter: ACC_WIDTH, 24, internal envelope accumulator width; env = acc[ACC_WIDTH-1 -: 16].
REQ-002 Port: clk  in  1  system clock, 100 MHz.
REQ-003 Port: reset_n  in  1  reset; one clock, asynchronous, active-low.
REQ-004 Port: en  in  1  sample tick (one clk wide, 25 MHz); all envelope updates occur only on en.
REQ-005 Port: gate  in  1  note gate level; high = key down.
REQ-006 Port: attack_step  in  16  per-tick increment in env LSBs (acc step = attack_step << 8).
REQ-007 Port: decay_step  in  16  per-tick decrement, same scaling.
REQ-008 Port: sustain_lvl  in  16  sustain level in env units; values above 0x4000 treated as 0x4000.
REQ-009 Port: release_step  in  16  per-tick decrement, same scaling.
REQ-010 Port: hold_ticks  in  16  en ticks spent at peak (present only with ADSR_HOLD_EN).
REQ-011 Port: env  out  16  envelope, Q2.14 (0x4000 = 1.0); drives the env input of ddfs.
REQ-012 Port: env_valid  out  1  one-clk pulse the cycle after each en update.
REQ-013 Port: active  out  1  high whenever state != IDLE.

Function
REQ-014 States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE (plus HOLD per REQ-029); state, acc, gate_q change only on clk edges where en = 1.
REQ-015 gate_q = gate sampled at previous en; rising edge = gate & ~gate_q at the current en.
REQ-016 IDLE: acc = 0; on gate high -> ATTACK.
REQ-017 ATTACK: acc += step; sum formed at ACC_WIDTH+1 bits; if sum >= 0x400000 then acc = 0x400000 and -> DECAY (or HOLD).
REQ-018 DECAY: if acc - step <= sustain<<8 (signed compare, no wrap) then acc = sustain<<8 and -> SUSTAIN, else acc -= step.
REQ-019 SUSTAIN: acc = sustain_lvl<<8 every en (tracks live sustain_lvl changes).
REQ-020 RELEASE: if acc <= step then acc = 0 and -> IDLE, else acc -= step.
REQ-021 gate low at en in ATTACK/HOLD/DECAY/SUSTAIN -> RELEASE from current acc, no step applied that tick; gate-low has priority over every other transition.
REQ-022 Rising edge at en in RELEASE/DECAY/SUSTAIN/HOLD -> ATTACK from current acc (no reset to 0, no click).
REQ-023 Zero step: acc unchanged, state unchanged (ATTACK with attack_step = 0 stalls until gate low).
REQ-024 env registered: reflects acc after the en update, valid one clk after en; env_valid = en delayed one clk.
REQ-025 env never exceeds 0x4000 and never underflows below 0x0000.

Reset
REQ-026 reset_n low: state = IDLE, acc = 0, gate_q = 0, env = 0x0000, env_valid = 0, active = 0, hold counter = 0.
REQ-027 Reset asserted mid-envelope: outputs go to reset values immediately (asynchronous); after release, first gate high at en starts ATTACK from 0.
REQ-028 First en after reset_n deassertion is processed normally.

Configuration
REQ-029 ADSR_HOLD_EN defined: hold_ticks port present; ATTACK peak -> HOLD; HOLD counts en ticks, acc = 0x400000, -> DECAY after hold_ticks ticks (hold_ticks = 0 -> DECAY on next en).
REQ-030 ADSR_HOLD_EN undefined: no hold_ticks port, no HOLD state, no counter; ATTACK peak -> DECAY directly.

Verification
REQ-031 attack_step 0x0100, gate high: env rises 0x0100 per en, reaches 0x4000 at 64th en, state DECAY.
REQ-032 decay_step 0x0080, sustain_lvl 0x2000: from 0x4000 reaches 0x2000 after 64 en, holds 0x2000 while gate high; sustain_lvl changed to 0x1000 -> env 0x1000 next en.
REQ-033 release_step 0x0100 from env 0x2000, gate low: 0x0000 after 32 en, active falls, state IDLE.
REQ-034 gate low mid-attack at env 0x1800 then high 4 en later (release_step 0x0100): env 0x1400, then attack resumes upward from 0x1400.
REQ-035 reset_n pulsed low during SUSTAIN: env 0x0000, env_valid 0, active 0 immediately; env_valid pulses exactly one clk after each subsequent en.
REQ-036 ADSR_HOLD_EN, hold_ticks 10: env stays 0x4000 for 10 en after peak before decaying; without macro, decay starts next en.
